rv32_mod_instruction_prefetch: RTL and testbench
================================================

RV32_MOD_INSTRUCTION_PREFETCH -- requirements
Module: rv32_mod_instruction_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter INITIAL_PC, default 32'h10000000, first fetch address after reset.
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard queue and redirect fetch.
REQ-006 flush_addr  input  32  redirect target; bits [1:0] forced to 0.
REQ-007 out_valid  output  1  head entry present.
REQ-008 out_ready  input  1  consumer accepts head entry.
REQ-009 out_instr  output  32  head instruction word.
REQ-010 out_addr  output  32  address the head word was fetched from.
REQ-011 out_err  output  1  head fetch completed with bus error.
REQ-012 count  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-013 instr_req  output  1  bus request.
REQ-014 instr_ack  input  1  bus completion, data valid.
REQ-015 instr_err  input  1  bus completion, error.
REQ-016 instr_addr  output  32  bus address, word aligned.
REQ-017 instr_data_i  input  32  bus read data.

Function
REQ-018 FIFO of DEPTH entries {instr, addr, err}; read/write pointers wrap modulo DEPTH; out_* show head entry combinationally from storage.
REQ-019 out_valid SHALL equal (count != 0); pop when out_valid && out_ready && !flush.
REQ-020 FSM states IDLE, REQ, DRAIN, HALT; instr_req = 1 exactly in REQ and DRAIN.
REQ-021 IDLE -> REQ when count (after this cycle's pop) < DEPTH; else stay IDLE.
REQ-022 REQ: instr_addr = fetch_addr; instr_req and instr_addr held stable until instr_ack or instr_err (completion); instr_ack and instr_err together count as error.
REQ-023 REQ completion without flush: push {instr_data_i, fetch_addr, instr_err}; fetch_addr += 4 (32-bit wrap); next state HALT if error, else REQ if post-push/pop count < DEPTH, else IDLE.
REQ-024 Push and pop in same cycle SHALL leave count unchanged; push at count == DEPTH cannot occur (guaranteed by REQ-021/REQ-023); any such push is a design error.
REQ-025 flush (any state): queue cleared (count 0, pointers 0), fetch_addr = {flush_addr[31:2], 2'b00}, same-cycle pop and push suppressed.
REQ-026 flush in REQ without completion: -> DRAIN; instr_req and original instr_addr held until completion, response discarded, then -> REQ at new fetch_addr.
REQ-027 flush in REQ with same-cycle completion, or in IDLE/HALT: response (if any) discarded, -> REQ.
REQ-028 flush in DRAIN: fetch_addr updated again; remains DRAIN until completion.
REQ-029 HALT: no requests; exited only by flush or reset; queued entries remain poppable.
REQ-030 Latency: completion in cycle N -> entry visible on out_* in cycle N+1.
REQ-031 Back-to-back: with space available, next request asserted in cycle after completion (one-cycle gap-free issue).

Reset
REQ-032 While reset high: state IDLE, fetch_addr = INITIAL_PC, count 0, pointers 0, instr_req 0, out_valid 0, instr_addr = INITIAL_PC.
REQ-033 First instr_req SHALL assert in the second cycle after reset deasserts.
REQ-034 Reset mid-transaction aborts it immediately; late instr_ack/instr_err after reset while not in REQ/DRAIN SHALL be ignored.
REQ-035 Storage contents need not be reset; only control state.

Verification
REQ-036 Reset release, ack every cycle, out_ready=0, DEPTH=4 -> fetches at 0x10000000..0x1000000C, count 4, instr_req deasserts, state IDLE.
REQ-037 Full queue, out_ready pulsed once -> one pop (out_addr 0x10000000), next cycle request 0x10000010 issues, count returns to 4.
REQ-038 Ack delayed 3 cycles, flush_addr=0x2000_0006 asserted in REQ -> instr_req held on old address until ack, response dropped, next request 0x20000004, count 0 after flush.
REQ-039 instr_err on 2nd fetch -> entries {0x10000000,err 0},{0x10000004,err 1}, no further requests until flush.
REQ-040 out_ready=1 continuously, ack every other cycle -> count never exceeds 1, out_addr strictly +4 per pop, no entry lost or duplicated.
REQ-041 Reset asserted during outstanding REQ -> instr_req 0 next cycle, count 0, refetch from INITIAL_PC.

Source files
------------

// File: rtl/rv32_mod_instruction_prefetch_if.sv
// Consumer-side queue head, flush/redirect and instruction-bus signals of the prefetch unit.
// The master modport is the prefetch unit's view; slave is the surrounding core/bus.
interface rv32_mod_instruction_prefetch_if #(
    parameter int DEPTH = 4
);
    logic                     flush;
    logic [31:0]              flush_addr;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_instr;
    logic [31:0]              out_addr;
    logic                     out_err;
    logic [$clog2(DEPTH):0]   count;
    logic                     instr_req;
    logic                     instr_ack;
    logic                     instr_err;
    logic [31:0]              instr_addr;
    logic [31:0]              instr_data_i;

    modport master (
        input  flush, flush_addr, out_ready, instr_ack, instr_err, instr_data_i,
        output out_valid, out_instr, out_addr, out_err, count, instr_req, instr_addr
    );

    modport slave (
        output flush, flush_addr, out_ready, instr_ack, instr_err, instr_data_i,
        input  out_valid, out_instr, out_addr, out_err, count, instr_req, instr_addr
    );
endinterface

// File: rtl/rv32_mod_instruction_prefetch.sv
// Instruction prefetch queue: issues sequential word fetches on a req/ack bus and buffers
// {instr, addr, err} in a DEPTH-entry FIFO; flush redirects, a bus error halts fetching.
module rv32_mod_instruction_prefetch #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] INITIAL_PC = 32'h10000000
) (
    input  logic                              clk,
    input  logic                              reset,
    rv32_mod_instruction_prefetch_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_addr, fetch_addr_next;
    logic [31:0]   drain_addr, drain_addr_next;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_after_pop;
    logic          done, pop, push;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_addr  [DEPTH];
    logic          mem_err   [DEPTH];

    // Redirect targets are word aligned, so the low flush_addr bits are never used.
    logic unused_flush_low;
    assign unused_flush_low = ^bus.flush_addr[1:0];

    assign done            = bus.instr_ack | bus.instr_err;
    assign pop             = (count != '0) && bus.out_ready && !bus.flush;
    assign count_after_pop = count - CW'(pop);

    always_comb begin
        state_next      = state;
        fetch_addr_next = fetch_addr;
        drain_addr_next = drain_addr;
        push            = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush || (count_after_pop < FULL))
                    state_next = REQ;
            end
            REQ: begin
                if (bus.flush) begin
                    // The old address must stay on the bus until its response arrives.
                    state_next      = done ? REQ : DRAIN;
                    drain_addr_next = fetch_addr;
                end else if (done) begin
                    push            = 1'b1;
                    fetch_addr_next = fetch_addr + 32'd4;
                    if (bus.instr_err)
                        state_next = HALT;
                    else if ((count_after_pop + CW'(1)) < FULL)
                        state_next = REQ;
                    else
                        state_next = IDLE;
                end
            end
            DRAIN: begin
                if (done)
                    state_next = REQ;
            end
            HALT: begin
                if (bus.flush)
                    state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush)
            fetch_addr_next = {bus.flush_addr[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= INITIAL_PC;
            drain_addr <= INITIAL_PC;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state      <= state_next;
            fetch_addr <= fetch_addr_next;
            drain_addr <= drain_addr_next;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count_after_pop + CW'(push);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_instr[wr_ptr] <= bus.instr_data_i;
            mem_addr[wr_ptr]  <= fetch_addr;
            mem_err[wr_ptr]   <= bus.instr_err;
        end
    end

    assign bus.out_valid  = (count != '0);
    assign bus.out_instr  = mem_instr[rd_ptr];
    assign bus.out_addr   = mem_addr[rd_ptr];
    assign bus.out_err    = mem_err[rd_ptr];
    assign bus.count      = count;
    assign bus.instr_req  = (state == REQ) || (state == DRAIN);
    assign bus.instr_addr = (state == DRAIN) ? drain_addr : fetch_addr;
endmodule

// File: tb/tb_rv32_mod_instruction_prefetch.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic,
// all compared every cycle against a queue-based behavioural model of the prefetcher.
module tb_rv32_mod_instruction_prefetch;
    localparam int          DEPTH      = 4;
    localparam logic [31:0] INITIAL_PC = 32'h10000000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rv32_mod_instruction_prefetch_if #(.DEPTH(DEPTH)) bif ();

    rv32_mod_instruction_prefetch #(.DEPTH(DEPTH), .INITIAL_PC(INITIAL_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of entries plus "request outstanding / response to drop".
    entry_t      mq[$];
    entry_t      m_new;
    logic [31:0] m_fetch, m_bus;
    logic        m_out, m_disc, m_halt, m_init = 1'b0;
    logic        m_done, m_pop;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic fl, input logic [31:0] fa,
                                 input logic rdy, input logic ack, input logic err);
        reset            = rst;
        bif.flush        = fl;
        bif.flush_addr   = fa;
        bif.out_ready    = rdy;
        bif.instr_ack    = ack;
        bif.instr_err    = err;
        bif.instr_data_i = $urandom;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_fetch = INITIAL_PC;
            m_bus   = INITIAL_PC;
            m_out   = 1'b0;
            m_disc  = 1'b0;
            m_halt  = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            m_done = m_out && (bif.instr_ack || bif.instr_err);
            m_pop  = (mq.size() != 0) && bif.out_ready && !bif.flush;
            if (bif.flush) begin
                mq.delete();
                m_fetch = {bif.flush_addr[31:2], 2'b00};
                m_halt  = 1'b0;
                if (m_out && !m_done) begin
                    m_disc = 1'b1;
                end else begin
                    m_out  = 1'b1;
                    m_disc = 1'b0;
                    m_bus  = m_fetch;
                end
            end else begin
                if (m_pop)
                    void'(mq.pop_front());
                if (m_out) begin
                    if (m_done) begin
                        if (m_disc) begin
                            m_disc = 1'b0;
                            m_bus  = m_fetch;
                        end else begin
                            m_new.instr = bif.instr_data_i;
                            m_new.addr  = m_bus;
                            m_new.err   = bif.instr_err;
                            mq.push_back(m_new);
                            m_fetch = m_fetch + 32'd4;
                            if (bif.instr_err) begin
                                m_halt = 1'b1;
                                m_out  = 1'b0;
                            end else if (mq.size() < DEPTH) begin
                                m_bus = m_fetch;
                            end else begin
                                m_out = 1'b0;
                            end
                        end
                    end
                end else if (!m_halt && mq.size() < DEPTH) begin
                    m_out = 1'b1;
                    m_bus = m_fetch;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            checkOutput("count", 32'(bif.count), 32'(mq.size()));
            checkOutput("out_valid", 32'(bif.out_valid), 32'(mq.size() != 0));
            checkOutput("instr_req", 32'(bif.instr_req), 32'(m_out));
            if (m_out)
                checkOutput("instr_addr", bif.instr_addr, m_bus);
            if (mq.size() != 0) begin
                checkOutput("out_addr", bif.out_addr, mq[0].addr);
                checkOutput("out_instr", bif.out_instr, mq[0].instr);
                checkOutput("out_err", 32'(bif.out_err), 32'(mq[0].err));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [31:0] prev_addr;
        logic        have_prev;
        logic        rdy, ack, err, fl;

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst_count", 32'(bif.count), 0);
        checkOutput("rst_valid", 32'(bif.out_valid), 0);
        checkOutput("rst_req", 32'(bif.instr_req), 0);
        checkOutput("rst_addr", bif.instr_addr, 32'h10000000);

        // Fill: ack every cycle, consumer stalled
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("first_req", 32'(bif.instr_req), 1);
        checkOutput("first_addr", bif.instr_addr, 32'h10000000);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("fill_count", 32'(bif.count), 4);
        checkOutput("fill_req", 32'(bif.instr_req), 0);
        checkOutput("fill_head", bif.out_addr, 32'h10000000);

        // Single pop from a full queue
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("pop_count", 32'(bif.count), 3);
        checkOutput("pop_req_addr", bif.instr_addr, 32'h10000010);
        checkOutput("pop_head", bif.out_addr, 32'h10000004);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("refill_count", 32'(bif.count), 4);
        checkOutput("refill_req", 32'(bif.instr_req), 0);

        // Flush while a request is outstanding with a delayed ack
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 32'h20000006, 1, 0, 0);
        checkOutput("flush_count", 32'(bif.count), 0);
        checkOutput("drain_req", 32'(bif.instr_req), 1);
        checkOutput("drain_addr", bif.instr_addr, 32'h10000014);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("drain_hold", bif.instr_addr, 32'h10000014);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("redirect_addr", bif.instr_addr, 32'h20000004);
        checkOutput("dropped_count", 32'(bif.count), 0);

        // Bus error on the second fetch halts the prefetcher
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("halt_count", 32'(bif.count), 2);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("halt_req", 32'(bif.instr_req), 0);
        checkOutput("halt_head_addr", bif.out_addr, 32'h10000000);
        checkOutput("halt_head_err", 32'(bif.out_err), 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("err_entry_addr", bif.out_addr, 32'h10000004);
        checkOutput("err_entry_err", 32'(bif.out_err), 1);
        applyStimulus(0, 1, 32'h10000100, 0, 0, 0);
        checkOutput("unhalt_addr", bif.instr_addr, 32'h10000100);

        // Streaming: consumer always ready, ack every other cycle
        applyStimulus(1, 0, 0, 0, 0, 0);
        have_prev = 1'b0;
        prev_addr = '0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(0, 0, 0, 1, (i % 2) == 1, 0);
            checkOutput("stream_le1", 32'(bif.count <= 1), 1);
            if (bif.out_valid) begin
                if (have_prev)
                    checkOutput("stream_seq", bif.out_addr, prev_addr + 32'd4);
                prev_addr = bif.out_addr;
                have_prev = 1'b1;
            end
        end

        // Reset in the middle of an outstanding request; late ack ignored
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("pre_rst_req", 32'(bif.instr_req), 1);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("abort_req", 32'(bif.instr_req), 0);
        checkOutput("abort_count", 32'(bif.count), 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("refetch_req", 32'(bif.instr_req), 1);
        checkOutput("refetch_addr", bif.instr_addr, INITIAL_PC);
        checkOutput("refetch_count", 32'(bif.count), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            ack = bif.instr_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            err = ack && ($urandom_range(0, 15) == 0);
            if (err && $urandom_range(0, 1) == 0)
                ack = 1'b0;
            applyStimulus($urandom_range(0, 499) == 0, fl, $urandom, rdy, ack, err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
